// File: rtl/d_mux.sv
// Registered 1:2 demultiplexer with per-output transfer counters.
// Counters and clear_i are built only when DMUX_CNT_EN is defined; otherwise the counts are tied to 0.
module d_mux #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             sel_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             a_valid_o,
    output logic             b_valid_o,
    output logic [CNT_W-1:0] a_cnt_o,
    output logic [CNT_W-1:0] b_cnt_o
);

    logic a_take;
    logic b_take;

    assign a_take = valid_i & ~sel_i;
    assign b_take = valid_i & sel_i;

    // The unselected side is driven to zero every cycle so it never holds stale data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_o       <= '0;
            b_o       <= '0;
            a_valid_o <= 1'b0;
            b_valid_o <= 1'b0;
        end else begin
            a_o       <= a_take ? in_i : '0;
            b_o       <= b_take ? in_i : '0;
            a_valid_o <= a_take;
            b_valid_o <= b_take;
        end
    end

`ifdef DMUX_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear wins over a same-cycle transfer; counts saturate instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_cnt_o <= '0;
            b_cnt_o <= '0;
        end else if (clear_i) begin
            a_cnt_o <= '0;
            b_cnt_o <= '0;
        end else begin
            if (a_take && (a_cnt_o != CNT_MAX)) begin
                a_cnt_o <= a_cnt_o + 1'b1;
            end
            if (b_take && (b_cnt_o != CNT_MAX)) begin
                b_cnt_o <= b_cnt_o + 1'b1;
            end
        end
    end
`else
    logic unused_clear;

    assign unused_clear = clear_i;
    assign a_cnt_o      = '0;
    assign b_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_d_mux.sv
// Self-checking bench for d_mux (WIDTH=8, CNT_W=2); counter expectations follow DMUX_CNT_EN.
module tb_d_mux;

    localparam int W  = 8;
    localparam int CW = 2;
    localparam int OW = 2 * W + 2 + 2 * CW;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [W-1:0]  in_i;
    logic          sel_i;
    logic          valid_i;
    logic          clear_i;
    logic [W-1:0]  a_o;
    logic [W-1:0]  b_o;
    logic          a_valid_o;
    logic          b_valid_o;
    logic [CW-1:0] a_cnt_o;
    logic [CW-1:0] b_cnt_o;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] obs;
    logic [OW-1:0] exp_v;
    logic [CW-1:0] m_a;
    logic [CW-1:0] m_b;
    int            checks;
    int            errors;

    d_mux #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_i      (in_i),
        .sel_i     (sel_i),
        .valid_i   (valid_i),
        .clear_i   (clear_i),
        .a_o       (a_o),
        .b_o       (b_o),
        .a_valid_o (a_valid_o),
        .b_valid_o (b_valid_o),
        .a_cnt_o   (a_cnt_o),
        .b_cnt_o   (b_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    assign obs = {a_o, b_o, a_valid_o, b_valid_o, a_cnt_o, b_cnt_o};

    // Drive one cycle of inputs and push the reference model's result for the next edge.
    task automatic apply(input logic v, input logic s, input logic [W-1:0] d, input logic c);
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        valid_i = v;
        sel_i   = s;
        in_i    = d;
        clear_i = c;
        ea = (v && !s) ? d : '0;
        eb = (v && s) ? d : '0;
`ifdef DMUX_CNT_EN
        if (c) begin
            m_a = '0;
            m_b = '0;
        end else begin
            if (v && !s && m_a != 2'd3) m_a = m_a + 2'd1;
            if (v && s && m_b != 2'd3) m_b = m_b + 2'd1;
        end
`else
        m_a = '0;
        m_b = '0;
`endif
        exp_q.push_back({ea, eb, v & ~s, v & s, m_a, m_b});
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        valid_i = 1'b1; sel_i = 1'b0; in_i = 8'hff; clear_i = 1'b0;
        m_a = '0; m_b = '0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_initial obs=%h exp=%h", obs, {OW{1'b0}});
        end
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_ignores_inputs obs=%h exp=%h", obs, {OW{1'b0}});
        end
        rst_i = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic test_zero_word();
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL zero_word obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_route();
        apply(1'b1, 1'b0, 8'h01, 1'b0);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL route_a obs=%h exp=%h", obs, exp_v);
        end
        apply(1'b1, 1'b1, 8'h01, 1'b0);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL route_b obs=%h exp=%h", obs, exp_v);
        end
        apply(1'b0, 1'b1, 8'hff, 1'b0);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL idle obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_saturate_clear();
        apply(1'b1, 1'b0, 8'h00, 1'b1);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL pre_clear obs=%h exp=%h", obs, exp_v);
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 8'(8'h10 + i), 1'b0);
            @(posedge clk_i); #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL saturate_%0d obs=%h exp=%h", i, obs, exp_v);
            end
        end
        apply(1'b1, 1'b1, 8'hc3, 1'b1);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL clear_with_transfer obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 9) == 0));
            @(posedge clk_i); #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random_%0d obs=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        apply(1'b1, 1'b1, 8'h5a, 1'b0);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL pre_reset_b obs=%h exp=%h", obs, exp_v);
        end
        // A word is in flight when reset hits between edges; it must be dropped.
        valid_i = 1'b1; sel_i = 1'b1; in_i = 8'ha5; clear_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset_immediate obs=%h exp=%h", obs, {OW{1'b0}});
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        valid_i = 1'b0;
        m_a = '0; m_b = '0;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL inflight_discarded obs=%h exp=%h", obs, {OW{1'b0}});
        end
        apply(1'b1, 1'b0, 8'h3c, 1'b0);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL post_reset_first obs=%h exp=%h", obs, exp_v);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero_word();
        test_route();
        test_saturate_clear();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained left=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_mux.md
D_MUX -- requirements
Module: d_mux

Interface
REQ-001 WIDTH, 1, data width of in_i, a_o and b_o.
REQ-002 CNT_W, 16, width of each per-output transfer counter.
REQ-003 The design SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 in_i  input  WIDTH  data to route.
REQ-007 sel_i  input  1  route select: 0 = output a, 1 = output b.
REQ-008 valid_i  input  1  in_i/sel_i are valid this cycle.
REQ-009 clear_i  input  1  synchronous clear of both counters.
REQ-010 a_o  output  WIDTH  registered output a.
REQ-011 b_o  output  WIDTH  registered output b.
REQ-012 a_valid_o  output  1  a_o carries a routed word.
REQ-013 b_valid_o  output  1  b_o carries a routed word.
REQ-014 a_cnt_o  output  CNT_W  number of words routed to a.
REQ-015 b_cnt_o  output  CNT_W  number of words routed to b.

Function
REQ-016 Latency SHALL be exactly one clock: outputs reflect the inputs sampled at the previous rising edge.
REQ-017 With valid_i=1 and sel_i=0, the next edge SHALL set a_o=in_i, a_valid_o=1, b_o=0, b_valid_o=0.
REQ-018 With valid_i=1 and sel_i=1, the next edge SHALL set b_o=in_i, b_valid_o=1, a_o=0, a_valid_o=0.
REQ-019 With valid_i=0, the next edge SHALL set a_o=0, b_o=0, a_valid_o=0, b_valid_o=0, regardless of in_i and sel_i.
REQ-020 The unselected output SHALL always be driven to all-zeros, never holding stale data.
REQ-021 Routing in_i=0 SHALL still assert the selected valid; valid and data are independent.
REQ-022 There is no backpressure; every valid_i cycle SHALL be accepted and routed.
REQ-023 Each accepted word SHALL increment the selected output's counter by 1 at the same edge it appears on that output.
REQ-024 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 clear_i=1 SHALL zero both counters at the next edge; if a transfer occurs in the same cycle, the clear SHALL take priority (counter = 0), and the data/valid outputs SHALL still update normally.
REQ-026 clear_i SHALL NOT affect the data or valid outputs.

Reset
REQ-027 Asserting rst_i SHALL immediately force a_o, b_o, a_valid_o, b_valid_o, a_cnt_o and b_cnt_o to 0, independent of clk_i.
REQ-028 While rst_i=1, inputs SHALL be ignored.
REQ-029 After rst_i deasserts, the first rising edge SHALL sample inputs normally.
REQ-030 Reset asserted mid-stream SHALL discard the word in flight; no counter increments for it.

Configuration
REQ-031 Macro DMUX_CNT_EN: when defined, the counters and clear_i logic SHALL be implemented as specified.
REQ-032 When DMUX_CNT_EN is undefined, a_cnt_o and b_cnt_o SHALL be tied to 0, clear_i SHALL be ignored, and all routing behaviour SHALL be unchanged.

Verification
REQ-033 Reset, then valid_i=1, in_i=0, sel_i=0 -> next edge: a_o=0, a_valid_o=1, b_o=0, b_valid_o=0, a_cnt_o=1.
REQ-034 valid_i=1, in_i=1, sel_i=0, then in_i=1, sel_i=1 -> a_o=1/b_o=0 after the first edge, a_o=0/b_o=1 after the second; a_cnt_o=1, b_cnt_o=1.
REQ-035 valid_i=0, in_i=1, sel_i=1 -> all data and valid outputs 0; counters unchanged.
REQ-036 CNT_W=2: route 5 words to b -> b_cnt_o holds 3; then assert clear_i with a simultaneous b transfer -> b_cnt_o=0, b_o=in_i.
REQ-037 Assert rst_i between clock edges while b_valid_o=1 -> all outputs 0 immediately, before the next edge.
REQ-038 Build without DMUX_CNT_EN, repeat REQ-034 -> identical data/valid outputs; a_cnt_o=b_cnt_o=0.
